wired_fcc_sched: RTL and testbench

In-order issue scheduler for the FCC execution unit. Buffers dispatched FCC-class instructions (fcmp, movxr2cf, movcf2xr, bceqz/bcnez, fsel, fclass) in a circular queue and captures source operands from wakeup broadcasts. Issues the queue head to the FCC unit through a valid/ready handshake only once both operands are present. Issue is strictly in order because every FCC instruction reads or writes the single fcc bit serially.

---
 rtl/wired_fcc_sched_pkg.sv | 27 ++
 rtl/wired_fcc_sched_if.sv | 29 ++
 rtl/wired_fcc_sched_operand.sv | 44 ++++
 rtl/wired_fcc_sched.sv | 96 +++++++++
 tb/tb_wired_fcc_sched.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/wired_fcc_sched_pkg.sv
// wired_fcc_sched_pkg: shared FCC scheduler types (request payload, operand slot, queue entry).
package wired_fcc_sched_pkg;
    localparam int TAG_W = 6;

    typedef enum logic [2:0] {
        FCC_FCMP, FCC_MOVXR2CF, FCC_MOVCF2XR, FCC_BCEQZ, FCC_BCNEZ, FCC_FSEL, FCC_FCLASS
    } fcc_op_e;

    typedef struct packed {
        fcc_op_e          op;
        logic [4:0]       cond;
        logic [TAG_W-1:0] dst;
        logic [31:0]      r0;
        logic [31:0]      r1;
    } iq_fcc_req_t;

    typedef struct packed {
        logic             rdy;
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
    } fcc_opnd_t;

    typedef struct packed {
        iq_fcc_req_t     req;
        fcc_opnd_t [1:0] src;
    } fcc_sched_entry_t;
endpackage

// File: rtl/wired_fcc_sched_if.sv
// wired_fcc_sched_if: dispatch, wakeup and issue bundle of the FCC scheduler.
interface wired_fcc_sched_if import wired_fcc_sched_pkg::*; #(
    parameter int DISP = 2,
    parameter int WKUP = 2
);
    logic [DISP-1:0]                  disp_valid;
    logic                             disp_ready;
    iq_fcc_req_t [DISP-1:0]           disp_req;
    logic [DISP-1:0][1:0][TAG_W-1:0]  disp_src_tag;
    logic [DISP-1:0][1:0]             disp_src_rdy;
    logic [DISP-1:0][1:0][31:0]       disp_src_data;
    logic [WKUP-1:0]                  wkup_valid;
    logic [WKUP-1:0][TAG_W-1:0]       wkup_tag;
    logic [WKUP-1:0][31:0]            wkup_data;
    logic                             ex_req_valid;
    logic                             ex_req_ready;
    iq_fcc_req_t                      ex_req;

    modport master (
        output disp_valid, disp_req, disp_src_tag, disp_src_rdy, disp_src_data,
        output wkup_valid, wkup_tag, wkup_data, ex_req_ready,
        input  disp_ready, ex_req_valid, ex_req
    );
    modport slave (
        input  disp_valid, disp_req, disp_src_tag, disp_src_rdy, disp_src_data,
        input  wkup_valid, wkup_tag, wkup_data, ex_req_ready,
        output disp_ready, ex_req_valid, ex_req
    );
endinterface

// File: rtl/wired_fcc_sched_operand.sv
// wired_fcc_sched_operand: one source operand slot; snoops wakeups on load and while waiting.
module wired_fcc_sched_operand import wired_fcc_sched_pkg::*; #(
    parameter int WKUP   = 2,
    parameter bit BYPASS = 1'b0
) (
    input  logic                       clk,
    input  logic                       load,
    input  fcc_opnd_t                  ld,
    input  logic [WKUP-1:0]            wk_valid,
    input  logic [WKUP-1:0][TAG_W-1:0] wk_tag,
    input  logic [WKUP-1:0][31:0]      wk_data,
    output logic                       ready,
    output logic [31:0]                value
);
    fcc_opnd_t        q;
    logic             hit;
    logic [31:0]      wd;
    logic [TAG_W-1:0] ct;

    // Descending scan so the lowest matching port is the last to assign.
    always_comb begin
        ct = load ? ld.tag : q.tag;
        hit = 1'b0;
        wd = '0;
        for (int i = WKUP - 1; i >= 0; i--) begin
            if (wk_valid[i] && wk_tag[i] == ct) begin
                hit = 1'b1;
                wd = wk_data[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            q <= '{rdy: ld.rdy | hit, tag: ld.tag, data: ld.rdy ? ld.data : wd};
        end else if (!q.rdy && hit) begin
            q.rdy <= 1'b1;
            q.data <= wd;
        end
    end

    assign ready = q.rdy | (BYPASS && hit && !load);
    assign value = q.rdy ? q.data : wd;
endmodule

// File: rtl/wired_fcc_sched.sv
// wired_fcc_sched: in-order FCC issue queue with wakeup capture.
// Define WIRED_FCC_SCHED_BYPASS_EN to let the head issue in the cycle its last operand is broadcast.
module wired_fcc_sched import wired_fcc_sched_pkg::*; #(
    parameter int DEPTH = 8,
    parameter int DISP  = 2,
    parameter int WKUP  = 2
) (
    input logic              clk,
    input logic              rst_n,
    input logic              flush,
    wired_fcc_sched_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = (DISP > 1) ? $clog2(DISP) : 1;
`ifdef WIRED_FCC_SCHED_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    iq_fcc_req_t          req_q [DEPTH];
    fcc_opnd_t            ld [DEPTH][2];
    logic [SW-1:0]        sel [DEPTH];
    logic [31:0]          op_val [DEPTH][2];
    logic [DEPTH-1:0][1:0] op_rdy;
    logic [DEPTH-1:0]     valid_q, wr;
    logic [AW-1:0]        head, tail, idx;
    logic [AW:0]          count, acc;
    logic                 fire, iss;

    assign bus.disp_ready = count <= (AW+1)'(DEPTH - DISP);
    assign fire = bus.disp_ready && |bus.disp_valid;

    // Valid slots are compacted onto consecutive entries starting at tail.
    always_comb begin
        wr = '0;
        acc = '0;
        idx = tail;
        for (int e = 0; e < DEPTH; e++) sel[e] = '0;
        for (int s = 0; s < DISP; s++) begin
            idx = tail + acc[AW-1:0];
            if (fire && bus.disp_valid[s]) begin
                wr[idx] = 1'b1;
                sel[idx] = SW'(s);
                acc = acc + (AW+1)'(1);
            end
        end
        for (int e = 0; e < DEPTH; e++)
            for (int k = 0; k < 2; k++)
                ld[e][k] = '{rdy: bus.disp_src_rdy[sel[e]][k], tag: bus.disp_src_tag[sel[e]][k],
                             data: bus.disp_src_data[sel[e]][k]};
    end

    for (genvar e = 0; e < DEPTH; e++) begin : g_e
        for (genvar k = 0; k < 2; k++) begin : g_k
            wired_fcc_sched_operand #(.WKUP(WKUP), .BYPASS(BYPASS)) u_op (
                .clk      (clk),
                .load     (wr[e]),
                .ld       (ld[e][k]),
                .wk_valid (bus.wkup_valid),
                .wk_tag   (bus.wkup_tag),
                .wk_data  (bus.wkup_data),
                .ready    (op_rdy[e][k]),
                .value    (op_val[e][k])
            );
        end
    end

    always_comb begin
        bus.ex_req = req_q[head];
        bus.ex_req.r0 = op_val[head][0];
        bus.ex_req.r1 = op_val[head][1];
    end

    assign bus.ex_req_valid = valid_q[head] && &op_rdy[head];
    assign iss = bus.ex_req_valid && bus.ex_req_ready;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            valid_q <= '0;
            head <= '0;
            tail <= '0;
            count <= '0;
        end else begin
            valid_q <= (valid_q & ~(DEPTH'(iss) << head)) | wr;
            head <= head + AW'(iss);
            tail <= tail + acc[AW-1:0];
            count <= count + acc - (AW+1)'(iss);
        end
    end

    always_ff @(posedge clk) begin
        for (int e = 0; e < DEPTH; e++)
            if (wr[e]) req_q[e] <= bus.disp_req[sel[e]];
    end
endmodule

// File: tb/tb_wired_fcc_sched.sv
// tb_wired_fcc_sched: directed and scoreboarded checks of the FCC scheduler.
module tb_wired_fcc_sched;
    import wired_fcc_sched_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [5:0] q [$];
    logic [5:0] next_id;
    iq_fcc_req_t held;

    wired_fcc_sched_if #(.DISP(2), .WKUP(2)) bus ();
    wired_fcc_sched #(.DEPTH(8), .DISP(2), .WKUP(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        bus.disp_valid = '0;
        bus.disp_req = '0;
        bus.disp_src_tag = '0;
        bus.disp_src_rdy = '0;
        bus.disp_src_data = '0;
        bus.wkup_valid = '0;
        bus.wkup_tag = '0;
        bus.wkup_data = '0;
    endtask

    task automatic set_slot(input int s, input logic [5:0] dst,
                            input logic r0ok, input logic [5:0] t0, input logic [31:0] d0,
                            input logic r1ok, input logic [5:0] t1, input logic [31:0] d1);
        bus.disp_valid[s] = 1'b1;
        bus.disp_req[s] = '{op: FCC_FCMP, cond: 5'd0, dst: dst, r0: 32'hDEAD, r1: 32'hBEEF};
        bus.disp_src_rdy[s][0] = r0ok;
        bus.disp_src_tag[s][0] = t0;
        bus.disp_src_data[s][0] = d0;
        bus.disp_src_rdy[s][1] = r1ok;
        bus.disp_src_tag[s][1] = t1;
        bus.disp_src_data[s][1] = d1;
    endtask

    task automatic set_wk(input int p, input logic [5:0] t, input logic [31:0] d);
        bus.wkup_valid[p] = 1'b1;
        bus.wkup_tag[p] = t;
        bus.wkup_data[p] = d;
    endtask

    initial begin
        clear_in();
        bus.ex_req_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst_valid", 96'(bus.ex_req_valid), 96'(0));
        chk("rst_ready", 96'(bus.disp_ready), 96'(1));
        chk("rst_count", 96'(dut.count), 96'(0));

        // single ready fcmp: issues the cycle after dispatch
        bus.ex_req_ready = 1'b1;
        set_slot(0, 6'd1, 1'b1, 6'd0, 32'h3F800000, 1'b1, 6'd0, 32'h40000000);
        #1;
        chk("t1_no_issue_yet", 96'(bus.ex_req_valid), 96'(0));
        tick();
        clear_in();
        #1;
        chk("t1_valid", 96'(bus.ex_req_valid), 96'(1));
        chk("t1_r0", 96'(bus.ex_req.r0), 96'(32'h3F800000));
        chk("t1_r1", 96'(bus.ex_req.r1), 96'(32'h40000000));
        chk("t1_op", 96'(bus.ex_req.op), 96'(FCC_FCMP));
        chk("t1_count1", 96'(dut.count), 96'(1));
        tick();
        chk("t1_count0", 96'(dut.count), 96'(0));
        chk("t1_empty", 96'(bus.ex_req_valid), 96'(0));

        // head waits on tag 5; the younger ready entry must not pass it
        set_slot(0, 6'd2, 1'b0, 6'd5, 32'h0, 1'b1, 6'd0, 32'h7);
        set_slot(1, 6'd3, 1'b1, 6'd0, 32'h1, 1'b1, 6'd0, 32'h2);
        tick();
        clear_in();
        #1;
        chk("t2_count", 96'(dut.count), 96'(2));
        chk("t2_blocked", 96'(bus.ex_req_valid), 96'(0));
        set_wk(0, 6'd5, 32'h1);
        #1;
`ifdef WIRED_FCC_SCHED_BYPASS_EN
        chk("t2_byp_valid", 96'(bus.ex_req_valid), 96'(1));
        chk("t2_byp_dst", 96'(bus.ex_req.dst), 96'(2));
        chk("t2_byp_r0", 96'(bus.ex_req.r0), 96'(1));
        tick();
        clear_in();
        #1;
`else
        chk("t2_no_bypass", 96'(bus.ex_req_valid), 96'(0));
        tick();
        clear_in();
        #1;
        chk("t2_valid", 96'(bus.ex_req_valid), 96'(1));
        chk("t2_dst_first", 96'(bus.ex_req.dst), 96'(2));
        chk("t2_r0", 96'(bus.ex_req.r0), 96'(1));
        chk("t2_r1", 96'(bus.ex_req.r1), 96'(7));
        tick();
`endif
        chk("t2_dst_second", 96'(bus.ex_req.dst), 96'(3));
        chk("t2_r1_second", 96'(bus.ex_req.r1), 96'(2));
        tick();
        chk("t2_drained", 96'(bus.ex_req_valid), 96'(0));
        chk("t2_count0", 96'(dut.count), 96'(0));

        // fill to 7, a further group is refused, one issue reopens dispatch
        bus.ex_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_slot(0, 6'(10 + 2 * i), 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, 32'h0);
            set_slot(1, 6'(11 + 2 * i), 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, 32'h0);
            tick();
            clear_in();
        end
        set_slot(0, 6'd16, 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, 32'h0);
        tick();
        clear_in();
        #1;
        chk("t3_count7", 96'(dut.count), 96'(7));
        chk("t3_not_ready", 96'(bus.disp_ready), 96'(0));
        chk("t3_head", 96'(bus.ex_req.dst), 96'(10));
        set_slot(0, 6'd20, 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, 32'h0);
        set_slot(1, 6'd21, 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, 32'h0);
        tick();
        clear_in();
        #1;
        chk("t3_no_write", 96'(dut.count), 96'(7));
        bus.ex_req_ready = 1'b1;
        tick();
        bus.ex_req_ready = 1'b0;
        #1;
        chk("t3_count6", 96'(dut.count), 96'(6));
        chk("t3_ready_again", 96'(bus.disp_ready), 96'(1));
        bus.ex_req_ready = 1'b1;
        for (int k = 11; k <= 16; k++) begin
            #1;
            chk("t3_drain_order", 96'(bus.ex_req.dst), 96'(k));
            tick();
        end
        chk("t3_empty", 96'(dut.count), 96'(0));

        // same-cycle dispatch and two matching wakeups: port 0 wins
        bus.ex_req_ready = 1'b0;
        set_wk(0, 6'd9, 32'hAAAA);
        set_wk(1, 6'd9, 32'h5555);
        set_slot(0, 6'd30, 1'b0, 6'd9, 32'h0, 1'b1, 6'd0, 32'h1);
        tick();
        clear_in();
        #1;
        chk("t4_valid", 96'(bus.ex_req_valid), 96'(1));
        chk("t4_r0_port0", 96'(bus.ex_req.r0), 96'(32'hAAAA));

        // stall for 4 cycles with a stray wakeup on the same tag, then flush
        held = '{op: FCC_FCMP, cond: 5'd0, dst: 6'd30, r0: 32'hAAAA, r1: 32'h1};
        for (int c = 0; c < 4; c++) begin
            set_wk(1, 6'd9, 32'h1234);
            tick();
            clear_in();
            #1;
            chk("t5_hold_valid", 96'(bus.ex_req_valid), 96'(1));
            chk("t5_hold_req", 96'(bus.ex_req), 96'(held));
        end
        flush = 1'b1;
        bus.ex_req_ready = 1'b1;
        set_slot(0, 6'd40, 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, 32'h0);
        tick();
        flush = 1'b0;
        clear_in();
        #1;
        chk("t5_flush_valid", 96'(bus.ex_req_valid), 96'(0));
        chk("t5_flush_count", 96'(dut.count), 96'(0));
        chk("t5_flush_ready", 96'(bus.disp_ready), 96'(1));

        // random rounds against an in-order scoreboard, crossing the pointer wrap
        next_id = 6'd1;
        for (int r = 0; r < 20; r++) begin
            int pat;
            int sz;
            logic rd;
            pat = $urandom_range(0, 3);
            rd = 1'($urandom_range(0, 1));
            sz = q.size();
            clear_in();
            bus.ex_req_ready = rd;
            if (pat[0]) set_slot(0, next_id, 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, 32'h0);
            if (pat[1]) set_slot(1, pat[0] ? next_id + 6'd1 : next_id, 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, 32'h0);
            #1;
            chk("rnd_valid", 96'(bus.ex_req_valid), 96'(sz != 0));
            chk("rnd_ready", 96'(bus.disp_ready), 96'(sz <= 6));
            if (sz != 0 && rd) begin
                chk("rnd_order", 96'(bus.ex_req.dst), 96'(q[0]));
                void'(q.pop_front());
            end
            if (sz <= 6) begin
                if (pat[0]) begin q.push_back(next_id); next_id++; end
                if (pat[1]) begin q.push_back(next_id); next_id++; end
            end
            tick();
            clear_in();
            #1;
            chk("rnd_count", 96'(dut.count), 96'(q.size()));
        end
        bus.ex_req_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (q.size() == 0) break;
            chk("drain_valid", 96'(bus.ex_req_valid), 96'(1));
            chk("drain_order", 96'(bus.ex_req.dst), 96'(q[0]));
            void'(q.pop_front());
            tick();
        end
        chk("drain_lost", 96'(q.size()), 96'(0));
        chk("drain_count", 96'(dut.count), 96'(0));
        chk("drain_empty", 96'(bus.ex_req_valid), 96'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
